// File: rtl/clock_time_setter.sv
// Time-set controller: debounces mode/inc buttons, runs the hours-then-minutes edit, emits a one-cycle commit.
// Optional macro AUTO_REPEAT_EN adds hold-to-repeat on the increment button.
module clock_time_setter #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int BLINK_DIV       = 8,
  parameter int HOUR_MAX        = 23,
  parameter int REPEAT_DELAY    = 32,
  parameter int REPEAT_RATE     = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic [6:0] cur_hours,
  input  logic [6:0] cur_minutes,
  output logic       set,
  output logic [6:0] set_hours,
  output logic [6:0] set_minutes,
  output logic       editing,
  output logic [1:0] edit_field,
  output logic       blink
);

  localparam int DBW    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int GATE_N = DEBOUNCE_CYCLES + 3;
  localparam int GW     = $clog2(GATE_N + 1);
  localparam int BW     = $clog2(BLINK_DIV + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_EDIT_H = 2'd1;
  localparam logic [1:0] S_EDIT_M = 2'd2;
  localparam logic [1:0] S_COMMIT = 2'd3;

  // Index 0 = mode button, index 1 = increment button.
  logic [1:0]          sync1_q, sync2_q;
  logic [1:0]          level_q, level_prev_q;
  logic [1:0]          press_q;
  logic [1:0][DBW-1:0] db_cnt_q;
  logic [GW-1:0]       gate_cnt_q;
  logic                gate_done_s;

  logic [1:0] state_q, state_d;
  logic [6:0] hours_q, hours_d;
  logic [6:0] mins_q, mins_d;
  logic       set_q, editing_q, blink_q;
  logic [1:0] field_q;
  logic [BW-1:0] blink_cnt_q;

  logic mode_p_s, inc_press_s, inc_p_s;
  logic in_edit_s, next_edit_s, entering_s;

  assign gate_done_s = (gate_cnt_q == GW'(GATE_N));
  assign mode_p_s    = press_q[0];
  assign inc_press_s = press_q[1];
  assign in_edit_s   = (state_q == S_EDIT_H) || (state_q == S_EDIT_M);
  assign next_edit_s = (state_d == S_EDIT_H) || (state_d == S_EDIT_M);
  assign entering_s  = next_edit_s && (state_d != state_q);

  // Synchronize, debounce and edge-detect both buttons; edges are gated off right after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q      <= 2'b00;
      sync2_q      <= 2'b00;
      level_q      <= 2'b00;
      level_prev_q <= 2'b00;
      press_q      <= 2'b00;
      db_cnt_q     <= '0;
      gate_cnt_q   <= '0;
    end else begin
      sync1_q <= {btn_inc, btn_mode};
      sync2_q <= sync1_q;
      for (int i = 0; i < 2; i++) begin
        if (sync2_q[i] != level_q[i]) begin
          if (db_cnt_q[i] == DBW'(DEBOUNCE_CYCLES - 1)) begin
            level_q[i]  <= sync2_q[i];
            db_cnt_q[i] <= '0;
          end else begin
            db_cnt_q[i] <= db_cnt_q[i] + DBW'(1);
          end
        end else begin
          db_cnt_q[i] <= '0;
        end
      end
      level_prev_q <= level_q;
      press_q      <= gate_done_s ? (level_q & ~level_prev_q) : 2'b00;
      if (!gate_done_s) begin
        gate_cnt_q <= gate_cnt_q + GW'(1);
      end
    end
  end

`ifdef AUTO_REPEAT_EN
  localparam int RW = $clog2(REPEAT_DELAY + 1);
  logic          rep_act_q, rep_act_d;
  logic [RW-1:0] rep_cnt_q, rep_cnt_d;
  logic          rep_fire_s;

  // Counter runs from the press pulse; first repeat after REPEAT_DELAY, then every REPEAT_RATE.
  always_comb begin
    rep_act_d  = rep_act_q;
    rep_cnt_d  = rep_cnt_q;
    rep_fire_s = 1'b0;
    if (!in_edit_s || mode_p_s || !level_q[1]) begin
      rep_act_d = 1'b0;
      rep_cnt_d = '0;
    end else if (inc_press_s) begin
      rep_act_d = 1'b1;
      rep_cnt_d = RW'(1);
    end else if (rep_act_q) begin
      if (rep_cnt_q == RW'(REPEAT_DELAY)) begin
        rep_fire_s = 1'b1;
        rep_cnt_d  = RW'(REPEAT_DELAY - REPEAT_RATE + 1);
      end else begin
        rep_cnt_d = rep_cnt_q + RW'(1);
      end
    end else begin
      rep_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rep_act_q <= 1'b0;
      rep_cnt_q <= '0;
    end else begin
      rep_act_q <= rep_act_d;
      rep_cnt_q <= rep_cnt_d;
    end
  end

  assign inc_p_s = inc_press_s | rep_fire_s;
`else
  logic unused_repeat_s;
  assign unused_repeat_s = (REPEAT_DELAY > 0) ^ (REPEAT_RATE > 0);
  assign inc_p_s = inc_press_s;
`endif

  // Edit sequence; mode takes priority over a same-cycle increment.
  always_comb begin
    state_d = state_q;
    hours_d = hours_q;
    mins_d  = mins_q;
    case (state_q)
      S_IDLE: begin
        if (mode_p_s) begin
          hours_d = (cur_hours > 7'(HOUR_MAX)) ? 7'd0 : cur_hours;
          mins_d  = (cur_minutes > 7'd59) ? 7'd0 : cur_minutes;
          state_d = S_EDIT_H;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_EDIT_H: begin
        if (mode_p_s) begin
          state_d = S_EDIT_M;
        end else if (inc_p_s) begin
          hours_d = (hours_q == 7'(HOUR_MAX)) ? 7'd0 : hours_q + 7'd1;
        end else begin
          state_d = S_EDIT_H;
        end
      end
      S_EDIT_M: begin
        if (mode_p_s) begin
          state_d = S_COMMIT;
        end else if (inc_p_s) begin
          mins_d = (mins_q == 7'd59) ? 7'd0 : mins_q + 7'd1;
        end else begin
          state_d = S_EDIT_M;
        end
      end
      S_COMMIT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // State, edit values and status outputs, all registered from the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      hours_q   <= 7'd0;
      mins_q    <= 7'd0;
      set_q     <= 1'b0;
      editing_q <= 1'b0;
      field_q   <= 2'd0;
    end else begin
      state_q   <= state_d;
      hours_q   <= hours_d;
      mins_q    <= mins_d;
      set_q     <= (state_d == S_COMMIT);
      editing_q <= next_edit_s;
      case (state_d)
        S_EDIT_H: field_q <= 2'd1;
        S_EDIT_M: field_q <= 2'd2;
        default:  field_q <= 2'd0;
      endcase
    end
  end

  // Blink divider restarts with blink low on every entry into an edit field.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blink_q     <= 1'b0;
      blink_cnt_q <= '0;
    end else if (!next_edit_s || entering_s) begin
      blink_q     <= 1'b0;
      blink_cnt_q <= '0;
    end else if (blink_cnt_q == BW'(BLINK_DIV - 1)) begin
      blink_q     <= ~blink_q;
      blink_cnt_q <= '0;
    end else begin
      blink_cnt_q <= blink_cnt_q + BW'(1);
    end
  end

  assign set         = set_q;
  assign set_hours   = hours_q;
  assign set_minutes = mins_q;
  assign editing     = editing_q;
  assign edit_field  = field_q;
  assign blink       = blink_q;

endmodule

// File: tb/tb_clock_time_setter.sv
// Bench for clock_time_setter: directed scenarios plus random button presses against a field-level model.
module tb_clock_time_setter;
  localparam int DB = 4;
  localparam int BD = 8;
  localparam int HM = 23;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn_mode = 1'b0;
  logic       btn_inc = 1'b0;
  logic [6:0] cur_hours = 7'd0;
  logic [6:0] cur_minutes = 7'd0;
  logic       set;
  logic [6:0] set_hours, set_minutes;
  logic       editing;
  logic [1:0] edit_field;
  logic       blink;

  clock_time_setter #(
    .DEBOUNCE_CYCLES(DB), .BLINK_DIV(BD), .HOUR_MAX(HM), .REPEAT_DELAY(32), .REPEAT_RATE(8)
  ) dut (
    .clk(clk), .reset(reset), .btn_mode(btn_mode), .btn_inc(btn_inc),
    .cur_hours(cur_hours), .cur_minutes(cur_minutes), .set(set),
    .set_hours(set_hours), .set_minutes(set_minutes), .editing(editing),
    .edit_field(edit_field), .blink(blink)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  // Model: field being edited (0 none, 1 hours, 2 minutes) and the edited values.
  int mdl_field = 0;
  int mdl_h = 0;
  int mdl_m = 0;
  int exp_sets = 0;
  int seen_sets = 0;
  int blink_k = 0;
  int prev_field = 0;
  int prev_set = 0;

  task automatic chk_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic model_press(input bit m, input bit i);
    if (mdl_field == 0) begin
      if (m) begin
        mdl_h = (int'(cur_hours) > HM) ? 0 : int'(cur_hours);
        mdl_m = (int'(cur_minutes) > 59) ? 0 : int'(cur_minutes);
        mdl_field = 1;
      end
    end else if (m) begin
      mdl_field = (mdl_field + 1) % 3;
      if (mdl_field == 0) exp_sets++;
    end else if (i) begin
      if (mdl_field == 1) mdl_h = (mdl_h + 1) % (HM + 1);
      else mdl_m = (mdl_m + 1) % 60;
    end
  endtask

  task automatic check_outputs(input string tag);
    chk_eq({tag, "_editing"}, editing, (mdl_field != 0) ? 1 : 0);
    chk_eq({tag, "_field"}, edit_field, mdl_field);
    chk_eq({tag, "_hours"}, set_hours, mdl_h);
    chk_eq({tag, "_minutes"}, set_minutes, mdl_m);
    chk_eq({tag, "_sets"}, seen_sets, exp_sets);
  endtask

  task automatic press(input bit m, input bit i, input int hold, input int gap, input string tag);
    btn_mode = m;
    btn_inc  = i;
    model_press(m, i);
    tick(hold);
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    tick(gap);
    check_outputs(tag);
  endtask

  task automatic model_reset();
    mdl_field = 0;
    mdl_h = 0;
    mdl_m = 0;
  endtask

  // Blink phase, commit pulse width and commit payload are watched every cycle.
  always @(negedge clk) begin
    if (reset) begin
      prev_field = 0;
      blink_k = 0;
      prev_set = 0;
    end else begin
      if (int'(edit_field) != prev_field) blink_k = 0;
      else blink_k++;
      prev_field = int'(edit_field);
      if (edit_field == 2'd0) chk_eq("blink_off", blink, 0);
      else chk_eq("blink_phase", blink, (blink_k / BD) % 2);
      if (set) begin
        seen_sets++;
        chk_eq("set_width", prev_set, 0);
        chk_eq("commit_hours", set_hours, mdl_h);
        chk_eq("commit_minutes", set_minutes, mdl_m);
        chk_eq("commit_editing", editing, 0);
      end
      prev_set = int'(set);
    end
  end

  initial begin
    tick(3);
    chk_eq("rst_set", set, 0);
    chk_eq("rst_hours", set_hours, 0);
    chk_eq("rst_minutes", set_minutes, 0);
    chk_eq("rst_editing", editing, 0);
    chk_eq("rst_field", edit_field, 0);
    chk_eq("rst_blink", blink, 0);
    reset = 1'b0;
    tick(12);

    // Full edit from 10:45 to 12:48.
    cur_hours = 7'd10; cur_minutes = 7'd45;
    press(1, 0, 10, 10, "full_mode1");
    press(0, 1, 10, 10, "full_inc_h");
    press(0, 1, 10, 10, "full_inc_h");
    press(1, 0, 10, 10, "full_mode2");
    for (int j = 0; j < 3; j++) press(0, 1, 10, 10, "full_inc_m");
    press(1, 0, 10, 10, "full_commit");
    chk_eq("full_h", set_hours, 12);
    chk_eq("full_m", set_minutes, 48);

    // Wrap from 23:59 to 0:00.
    cur_hours = 7'd23; cur_minutes = 7'd59;
    press(1, 0, 10, 10, "wrap_mode1");
    press(0, 1, 10, 10, "wrap_inc_h");
    press(1, 0, 10, 10, "wrap_mode2");
    press(0, 1, 10, 10, "wrap_inc_m");
    press(1, 0, 10, 10, "wrap_commit");
    chk_eq("wrap_h", set_hours, 0);
    chk_eq("wrap_m", set_minutes, 0);

    // Out-of-range capture loads zeros.
    cur_hours = 7'd30; cur_minutes = 7'd75;
    press(1, 0, 10, 10, "oor_capture");
    press(1, 0, 10, 10, "oor_mode2");
    press(1, 0, 10, 10, "oor_commit");

    // Bounce on inc, then hold: one increment, press pulse 7 cycles after the final rise.
    cur_hours = 7'd3; cur_minutes = 7'd10;
    press(1, 0, 10, 10, "bounce_enter");
    for (int j = 0; j < 5; j++) begin
      btn_inc = 1'b1; tick(2);
      btn_inc = 1'b0; tick(2);
    end
    btn_inc = 1'b1;
    tick(7);
    chk_eq("bounce_before_pulse", set_hours, 3);
    tick(1);
    chk_eq("bounce_after_pulse", set_hours, 4);
    model_press(0, 1);
    tick(10);
    btn_inc = 1'b0;
    tick(12);
    check_outputs("bounce_done");
    press(1, 0, 10, 10, "bounce_mode2");
    press(1, 0, 10, 10, "bounce_commit");

    // Simultaneous mode and inc in EDIT_H at hour 7.
    cur_hours = 7'd7; cur_minutes = 7'd20;
    press(1, 0, 10, 10, "simul_enter");
    press(1, 1, 10, 10, "simul_both");
    chk_eq("simul_hours", set_hours, 7);
    chk_eq("simul_field", edit_field, 2);
    press(1, 0, 10, 10, "simul_commit");

    // Reset in EDIT_M with 05:30: no commit, outputs cleared, next press recaptures.
    cur_hours = 7'd5; cur_minutes = 7'd30;
    press(1, 0, 10, 10, "rmid_enter");
    press(1, 0, 10, 10, "rmid_edit_m");
    reset = 1'b1;
    model_reset();
    tick(2);
    chk_eq("rmid_set", set, 0);
    chk_eq("rmid_blink", blink, 0);
    check_outputs("rmid_in_reset");
    reset = 1'b0;
    tick(12);
    check_outputs("rmid_after");
    cur_hours = 7'd11; cur_minutes = 7'd22;
    press(1, 0, 10, 10, "rmid_recapture");
    press(1, 0, 10, 10, "rmid_mode2");
    press(1, 0, 10, 10, "rmid_commit");

    // Mode held through reset produces no press.
    btn_mode = 1'b1;
    reset = 1'b1;
    model_reset();
    tick(2);
    reset = 1'b0;
    tick(20);
    chk_eq("held_reset_editing", editing, 0);
    btn_mode = 1'b0;
    tick(12);
    check_outputs("held_reset_release");
    press(1, 0, 10, 10, "held_reset_repress");

    // Random presses with random current time.
    for (int n = 0; n < 80; n++) begin
      int r;
      cur_hours   = 7'($urandom_range(0, 127));
      cur_minutes = 7'($urandom_range(0, 127));
      r = int'($urandom_range(0, 5));
      press((r < 2) || (r == 2), (r >= 2), int'($urandom_range(8, 14)),
            int'($urandom_range(8, 14)), "rand");
    end
    while (mdl_field != 0) press(1, 0, 10, 10, "rand_flush");

`ifdef AUTO_REPEAT_EN
    // Hold inc about 60 cycles past its press pulse in EDIT_M from 58.
    cur_hours = 7'd4; cur_minutes = 7'd58;
    press(1, 0, 10, 10, "rep_enter");
    press(1, 0, 10, 10, "rep_edit_m");
    btn_inc = 1'b1;
    tick(7 + 54);
    btn_inc = 1'b0;
    for (int j = 0; j < 5; j++) model_press(0, 1);
    tick(16);
    check_outputs("rep_done");
    chk_eq("rep_minutes", set_minutes, 3);
    press(1, 0, 10, 10, "rep_commit");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/clock_time_setter.md
Name: clock_time_setter

Overview:
- User-facing time-set controller for the digital clock.
- Debounces two push-buttons (mode, increment) and runs a hours-then-minutes edit sequence.
- Drives the set/set-value inputs of the hour and minute counters.
- Issues a single-cycle commit pulse carrying the edited time; the counters load it on that pulse.

Parameters:
DEBOUNCE_CYCLES, 16, consecutive stable samples required before a button state change is accepted
BLINK_DIV, 8, clk cycles per half-period of the blink output while editing
HOUR_MAX, 23, highest hour value; hour field wraps HOUR_MAX -> 0
REPEAT_DELAY, 32, held cycles before auto-repeat starts (only with AUTO_REPEAT_EN)
REPEAT_RATE, 8, cycles between auto-repeat increments (only with AUTO_REPEAT_EN)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-high; returns block to IDLE
btn_mode  input  1  raw mode button, asynchronous, active-high
btn_inc  input  1  raw increment button, asynchronous, active-high
cur_hours  input  7  current hours from hour counter
cur_minutes  input  7  current minutes from minute counter
set  output  1  one-cycle commit pulse to both counters
set_hours  output  7  edited hours value
set_minutes  output  7  edited minutes value
editing  output  1  high in EDIT_H or EDIT_M
edit_field  output  2  0 = none, 1 = hours, 2 = minutes
blink  output  1  display-blink strobe for the field being edited

Behaviour:
- Reset values: set = 0, set_hours = 0, set_minutes = 0, editing = 0, edit_field = 0, blink = 0. FSM in IDLE; debounce and blink counters cleared.
- Input conditioning:
  - Each button goes through a 2-flop synchronizer, then a debounce counter.
  - The debounced level changes only after DEBOUNCE_CYCLES consecutive synchronized samples differ from it.
  - Any bounce restarts the count.
  - A debounced 0->1 transition gives a one-cycle press pulse (mode_p, inc_p).
  - Latency from a clean raw edge to the press pulse is DEBOUNCE_CYCLES + 3 cycles.
  - A release never produces a pulse.
- FSM states: IDLE, EDIT_H, EDIT_M, COMMIT.
- IDLE:
  - On mode_p, capture cur_hours into set_hours and cur_minutes into set_minutes, then go to EDIT_H.
  - A captured hours value > HOUR_MAX loads 0; a captured minutes value > 59 loads 0.
  - inc_p is ignored.
- EDIT_H:
  - On inc_p: set_hours = (set_hours == HOUR_MAX) ? 0 : set_hours + 1.
  - On mode_p: go to EDIT_M.
- EDIT_M:
  - On inc_p: set_minutes = (set_minutes == 59) ? 0 : set_minutes + 1.
  - On mode_p: go to COMMIT.
- COMMIT: set = 1 for exactly this cycle, with set_hours/set_minutes stable; next state is IDLE unconditionally.
- Button pulses arriving during COMMIT are dropped.
- Simultaneous mode_p and inc_p in the same cycle: mode wins, the increment is discarded.
- set_hours/set_minutes hold their last value in IDLE (registered, no glitches). Arithmetic is unsigned 7-bit; overflow is impossible given the wrap rules.
- editing = 1 and edit_field = 1/2 in EDIT_H/EDIT_M; otherwise editing = 0 and edit_field = 0.
- blink:
  - Forced 0 in IDLE and COMMIT.
  - On entry to EDIT_H or EDIT_M, blink is cleared and the divider restarts.
  - It then toggles every BLINK_DIV cycles.
- Reset asserted mid-edit: immediate return to IDLE, no set pulse, edits discarded. The outputs take their reset values.
- A button held through reset produces no press pulse after release of reset until it is released and pressed again. The debounced level resets to 0 and the synchronized input is 1, so the level re-qualifies, but the edge detector is gated off for the first DEBOUNCE_CYCLES + 3 cycles after reset.

Optional Feature:
- Macro: AUTO_REPEAT_EN.
- Defined: in EDIT_H/EDIT_M, if the debounced inc level stays high for REPEAT_DELAY cycles after its press pulse, an extra increment pulse fires. Further pulses follow every REPEAT_RATE cycles while the button is held. Release stops repeat immediately. A mode_p cancels repeat.
- Not defined: exactly one increment per debounced press; REPEAT_DELAY and REPEAT_RATE are unused.

Test Plan:
- Bench parameters for all scenarios: DEBOUNCE_CYCLES = 4, BLINK_DIV = 8, HOUR_MAX = 23.
- Full edit: cur = 10:45; press mode, inc x2, mode, inc x3, mode -> single set pulse with set_hours = 12, set_minutes = 48; editing = 0 afterwards.
- Wrap: cur = 23:59; mode, inc, mode, inc, mode -> set pulse with 0:00.
- Bounce: btn_inc toggles every 2 cycles for 20 cycles, then holds high in EDIT_H -> exactly one increment, pulse 7 cycles after the final rising edge.
- Reset mid-edit: reset asserted in EDIT_M with edit 05:30 -> set never pulses; all outputs 0; next mode press recaptures cur values.
- Simultaneous: mode and inc pressed in the same cycle in EDIT_H at hours 7 -> state EDIT_M, set_hours stays 7.
- AUTO_REPEAT_EN with REPEAT_DELAY = 32, REPEAT_RATE = 8: hold inc 60 cycles past the press pulse in EDIT_M from 58 -> minutes go 59, 0, 1, 2, 3 (press pulse plus repeats at +32, +40, +48, +56).
